// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one Uart8 transmitter among byte producers
// Optional tag byte ahead of each payload: define UART_TX_ARB_TAG_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int ID_WIDTH      = 2,
    parameter int START_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [NUM_REQ-1:0]   reqValid,
    input  logic [8*NUM_REQ-1:0] reqData,
    output logic [NUM_REQ-1:0]   reqAck,
    output logic                 uartTxEn,
    output logic                 uartTxStart,
    output logic [7:0]           uartTxIn,
    input  logic                 uartTxBusy,
    input  logic                 uartTxDone,
    output logic                 busy,
    output logic                 sentValid,
    output logic                 sentErr,
    output logic [ID_WIDTH-1:0]  sentId
);

    localparam int CNT_W = $clog2(START_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_WAIT_DONE = 3'd2;
`ifdef UART_TX_ARB_TAG_EN
    localparam logic [2:0] S_TAG_START = 3'd3;
    localparam logic [2:0] S_TAG_WAIT  = 3'd4;
`endif

    logic [2:0]          state;
    logic [ID_WIDTH-1:0] rr_ptr;
    logic [ID_WIDTH-1:0] hold_id;
    logic [7:0]          hold_data;
    logic [CNT_W-1:0]    cnt;

    logic                grant_any;
    logic [ID_WIDTH-1:0] grant_id;
    logic                grant;
    logic                in_start;
    logic                in_wait;
    logic                timeout_hit;
    logic [ID_WIDTH-1:0] next_rr;
    logic [2:0]          first_state;
    logic [2:0]          wait_state;
    logic [2:0]          after_wait;

    // Scan rr_ptr, rr_ptr+1, ... modulo NUM_REQ; the first valid requester wins.
    always_comb begin
        logic [ID_WIDTH:0] sum;
        sum       = '0;
        grant_any = 1'b0;
        grant_id  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, rr_ptr} + (ID_WIDTH+1)'(i);
            if (sum >= (ID_WIDTH+1)'(NUM_REQ)) begin
                sum = sum - (ID_WIDTH+1)'(NUM_REQ);
            end
            if (!grant_any && reqValid[sum[ID_WIDTH-1:0]]) begin
                grant_any = 1'b1;
                grant_id  = sum[ID_WIDTH-1:0];
            end
        end
    end

`ifdef UART_TX_ARB_TAG_EN
    assign in_start    = (state == S_START) || (state == S_TAG_START);
    assign in_wait     = (state == S_WAIT_DONE) || (state == S_TAG_WAIT);
    assign first_state = S_TAG_START;
    assign wait_state  = (state == S_TAG_START) ? S_TAG_WAIT : S_WAIT_DONE;
    assign after_wait  = (state == S_TAG_WAIT) ? S_START : S_IDLE;
    assign uartTxIn    = (state == S_TAG_START) ? (8'hF0 | 8'(hold_id)) : hold_data;
`else
    assign in_start    = (state == S_START);
    assign in_wait     = (state == S_WAIT_DONE);
    assign first_state = S_START;
    assign wait_state  = S_WAIT_DONE;
    assign after_wait  = S_IDLE;
    assign uartTxIn    = hold_data;
`endif

    assign grant       = en && grant_any && (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign reqAck      = (grant && !reset) ? (NUM_REQ'(1) << grant_id) : '0;
    // Holding the enable through the whole byte keeps a late en drop from cutting a frame.
    assign uartTxEn    = !reset && (en || busy);
    assign uartTxStart = in_start;
    // Busy rising on the terminal count takes priority, so no error in that cycle.
    assign timeout_hit = in_start && !uartTxBusy && (cnt == CNT_LAST);
    assign sentValid   = (state == S_WAIT_DONE) && uartTxDone;
    assign sentErr     = timeout_hit;
    assign sentId      = hold_id;
    assign next_rr     = (hold_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : hold_id + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            hold_id   <= '0;
            hold_data <= '0;
            cnt       <= '0;
        end else if (state == S_IDLE) begin
            if (grant) begin
                hold_data <= reqData[8*grant_id +: 8];
                hold_id   <= grant_id;
                cnt       <= '0;
                state     <= first_state;
            end
        end else if (in_start) begin
            if (uartTxBusy) begin
                state <= wait_state;
                cnt   <= '0;
            end else if (timeout_hit) begin
                state  <= S_IDLE;
                rr_ptr <= next_rr;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else if (in_wait) begin
            if (uartTxDone) begin
                state <= after_wait;
                cnt   <= '0;
                if (after_wait == S_IDLE) begin
                    rr_ptr <= next_rr;
                end
            end
        end else begin
            state <= S_IDLE;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  reqValid;
    logic [31:0] reqData;
    logic [3:0]  reqAck;
    logic        uartTxEn;
    logic        uartTxStart;
    logic [7:0]  uartTxIn;
    logic        uartTxBusy;
    logic        uartTxDone;
    logic        busy;
    logic        sentValid;
    logic        sentErr;
    logic [1:0]  sentId;

    int tests  = 0;
    int failed = 0;
    int n;

    logic [3:0] wrap_valid [4];
    int         wrap_id    [4];

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(4), .ID_WIDTH(2), .START_TIMEOUT(1024)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .reqValid    (reqValid),
        .reqData     (reqData),
        .reqAck      (reqAck),
        .uartTxEn    (uartTxEn),
        .uartTxStart (uartTxStart),
        .uartTxIn    (uartTxIn),
        .uartTxBusy  (uartTxBusy),
        .uartTxDone  (uartTxDone),
        .busy        (busy),
        .sentValid   (sentValid),
        .sentErr     (sentErr),
        .sentId      (sentId)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // One Uart8 frame: accept the start, hold busy, then pulse done.
    task automatic frame(input logic [7:0] exp_byte, input logic exp_sent, input logic [1:0] exp_id);
        int w = 0;
        while (!uartTxStart && w < 20) begin
            tick();
            w++;
        end
        check("frame_start", uartTxStart, 1);
        check("frame_byte", uartTxIn, exp_byte);
        uartTxBusy = 1'b1;
        tick();
        check("start_drop", uartTxStart, 0);
        tick();
        uartTxBusy = 1'b0;
        uartTxDone = 1'b1;
        #1;
        check("sent_valid", sentValid, exp_sent);
        check("sent_err_low", sentErr, 0);
        if (exp_sent) check("sent_id", sentId, exp_id);
        tick();
        uartTxDone = 1'b0;
        #1;
    endtask

    task automatic serve(input logic [7:0] data, input logic [1:0] id);
`ifdef UART_TX_ARB_TAG_EN
        frame(8'hF0 | {6'd0, id}, 1'b0, id);
`endif
        frame(data, 1'b1, id);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; en = 1'b1; reqValid = 4'hF; reqData = 32'h4433_2211;
        uartTxBusy = 1'b0; uartTxDone = 1'b0;
        tick(); tick();
        check("rst_reqAck", reqAck, 0);
        check("rst_txEn", uartTxEn, 0);
        check("rst_txStart", uartTxStart, 0);
        check("rst_txIn", uartTxIn, 0);
        check("rst_busy", busy, 0);
        check("rst_sentValid", sentValid, 0);
        check("rst_sentErr", sentErr, 0);
        check("rst_sentId", sentId, 0);
        reqValid = 4'h0; en = 1'b0; reset = 1'b0;
        tick();
        check("idle_busy", busy, 0);

        // Single byte from requester 0
        en = 1'b1; reqValid = 4'b0001; reqData[7:0] = 8'h8A;
        #1;
        check("basic_ack", reqAck, 4'b0001);
        tick();
        reqValid = 4'b0000;
        check("basic_no_ack", reqAck, 0);
        check("basic_busy", busy, 1);
        uartTxDone = 1'b1;
        #1;
        check("done_ignored", sentValid, 0);
        uartTxDone = 1'b0;
        serve(8'h8A, 2'd0);
        check("basic_idle", busy, 0);

        // Round robin from a fresh pointer: 0,1,2,3,0
        reset = 1'b1; tick(); reset = 1'b0; tick();
        reqData = 32'h4433_2211; reqValid = 4'hF;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("rr_ack", reqAck, 4'b0001 << (k % 4));
            tick();
            serve(8'(8'h11 * ((k % 4) + 1)), 2'(k % 4));
        end
        reqValid = 4'h0;

        // Scan order and wrap; pointer starts at 1
        wrap_valid[0] = 4'b1010; wrap_id[0] = 1;
        wrap_valid[1] = 4'b1010; wrap_id[1] = 3;
        wrap_valid[2] = 4'b1010; wrap_id[2] = 1;
        wrap_valid[3] = 4'b0010; wrap_id[3] = 1;
        for (int k = 0; k < 4; k++) begin
            reqValid = wrap_valid[k];
            #1;
            check("wrap_ack", reqAck, 4'b0001 << wrap_id[k]);
            tick();
            reqValid = 4'h0;
            serve(8'(8'h11 * (wrap_id[k] + 1)), 2'(wrap_id[k]));
        end

        // Start timeout: transmitter never goes busy
        reqValid = 4'b0001; reqData[7:0] = 8'h5C;
        #1;
        check("to_ack", reqAck, 4'b0001);
        tick();
        reqValid = 4'h0;
        n = 1;
        while (!sentErr && n < 2000) begin
            tick();
            n++;
        end
        check("to_cycles", n, 1024);
        check("to_sentErr", sentErr, 1);
        check("to_sentId", sentId, 0);
        check("to_no_valid", sentValid, 0);
        tick();
        check("to_idle", busy, 0);
        check("to_err_pulse", sentErr, 0);
        reqValid = 4'b0001; reqData[7:0] = 8'hC3;
        #1;
        check("after_to_ack", reqAck, 4'b0001);
        tick();
        reqValid = 4'h0;
        serve(8'hC3, 2'd0);

        // Busy rising on the terminal count wins over the timeout
        reqValid = 4'b0010;
        #1;
        check("bw_ack", reqAck, 4'b0010);
        tick();
        reqValid = 4'h0;
        repeat (1023) tick();
        uartTxBusy = 1'b1;
        #1;
        check("bw_no_err", sentErr, 0);
        tick();
        check("bw_start_low", uartTxStart, 0);
        check("bw_busy", busy, 1);
        uartTxBusy = 1'b0;
        uartTxDone = 1'b1;
        #1;
`ifdef UART_TX_ARB_TAG_EN
        check("bw_tag_done", sentValid, 0);
`else
        check("bw_done", sentValid, 1);
`endif
        tick();
        uartTxDone = 1'b0;
`ifdef UART_TX_ARB_TAG_EN
        frame(8'h22, 1'b1, 2'd1);
`endif
        check("bw_idle", busy, 0);

        // Drop en in WAIT_DONE: frame completes, no new grant while en low
        reqValid = 4'b0100; reqData[23:16] = 8'h9E;
        #1;
        check("en_ack", reqAck, 4'b0100);
        tick();
        reqValid = 4'h0;
`ifdef UART_TX_ARB_TAG_EN
        frame(8'hF2, 1'b0, 2'd2);
`endif
        check("en_byte", uartTxIn, 8'h9E);
        uartTxBusy = 1'b1;
        tick();
        en = 1'b0; reqValid = 4'b0001;
        #1;
        check("en_txEn_held", uartTxEn, 1);
        check("en_no_ack", reqAck, 0);
        tick(); tick();
        check("en_txEn_held2", uartTxEn, 1);
        uartTxBusy = 1'b0;
        uartTxDone = 1'b1;
        #1;
        check("en_sentValid", sentValid, 1);
        check("en_sentId", sentId, 2);
        tick();
        uartTxDone = 1'b0;
        #1;
        check("en_idle", busy, 0);
        check("en_txEn_low", uartTxEn, 0);
        check("en_idle_no_ack", reqAck, 0);
        tick();
        check("en_idle_no_ack2", reqAck, 0);
        en = 1'b1;
        #1;
        check("en_resume_ack", reqAck, 4'b0001);
        tick();
        reqValid = 4'h0;
        serve(8'hC3, 2'd0);

`ifdef UART_TX_ARB_TAG_EN
        reqValid = 4'b0100; reqData[23:16] = 8'h7A;
        #1;
        check("tag_ack", reqAck, 4'b0100);
        tick();
        reqValid = 4'h0;
        frame(8'hF2, 1'b0, 2'd2);
        frame(8'h7A, 1'b1, 2'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
